// File: rtl/fifo_ext_pkg.sv
// rtl/fifo_ext_pkg.sv - shared types and helpers for the extended FIFO
package fifo_ext_pkg;

  // How the read side presents data on q_o
  typedef enum logic {
    NORMAL    = 1'b0,
    SHOWAHEAD = 1'b1
  } read_mode_t;

  // Number of words held by a FIFO with the given address width
  function automatic int fifo_depth(input int awidth);
    return 1 << awidth;
  endfunction

  // Turns the integer SHOWAHEAD parameter into a read mode
  function automatic read_mode_t decode_mode(input int showahead);
    return (showahead != 0) ? SHOWAHEAD : NORMAL;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port RAM with registered read data
module fifo_ram #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
)(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AWIDTH-1:0] raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);
  import fifo_ext_pkg::*;

  localparam int DEPTH = fifo_depth(AWIDTH);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Write port; the array carries no reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Read port; returns the pre-write contents on a same-address collision
  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/fifo_ext.sv
// rtl/fifo_ext.sv - single-clock FIFO with show-ahead, thresholds, error flags and flush
module fifo_ext #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int SHOWAHEAD = 1
)(
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic              flush_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  input  logic [AWIDTH:0]   af_thresh_i,
  input  logic [AWIDTH:0]   ae_thresh_i,
  input  logic              err_clr_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);
  import fifo_ext_pkg::*;

  localparam read_mode_t      MODE    = decode_mode(SHOWAHEAD);
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(fifo_depth(AWIDTH));

  logic [AWIDTH:0]   wr_ptr_q;
  logic [AWIDTH:0]   rd_ptr_q;
  logic [AWIDTH:0]   rd_ptr_nxt;
  logic [AWIDTH:0]   usedw_q;
  logic [AWIDTH:0]   usedw_nxt;
  logic              full_q;
  logic              empty_w;
  logic              wr_acc;
  logic              rd_acc;
  logic              collide;
  logic              ovf_q;
  logic              unf_q;
  logic              byp_sel_q;
  logic [DWIDTH-1:0] byp_data_q;
  logic              ram_we;
  logic              ram_re;
  logic [AWIDTH-1:0] ram_raddr;
  logic [DWIDTH-1:0] ram_q;

  // Request acceptance, next pointer/count and RAM port control
  always_comb begin
    empty_w    = (usedw_q == '0);
    wr_acc     = wrreq_i && !full_q;
    rd_acc     = rdreq_i && !empty_w;
    rd_ptr_nxt = rd_ptr_q + (AWIDTH+1)'(rd_acc);
    usedw_nxt  = usedw_q;
    case ({wr_acc, rd_acc})
      2'b10:   usedw_nxt = usedw_q + 1'b1;
      2'b01:   usedw_nxt = usedw_q - 1'b1;
      default: usedw_nxt = usedw_q;
    endcase
    // The word being written this cycle becomes the head next cycle
    collide = wr_acc && (wr_ptr_q == rd_ptr_nxt);
    ram_we  = wr_acc && !flush_i && !srst_i;
    if (MODE == fifo_ext_pkg::SHOWAHEAD) begin
      // Continuously prefetch whatever will be the head next cycle
      ram_re    = 1'b1;
      ram_raddr = rd_ptr_nxt[AWIDTH-1:0];
    end else begin
      // Only fetch on an accepted read so q_o holds between reads
      ram_re    = rd_acc && !flush_i && !srst_i;
      ram_raddr = rd_ptr_q[AWIDTH-1:0];
    end
  end

  // Pointers, word count and full flag
  always_ff @(posedge clk_i) begin
    if (srst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + (AWIDTH+1)'(wr_acc);
      rd_ptr_q <= rd_ptr_nxt;
      usedw_q  <= usedw_nxt;
      full_q   <= (usedw_nxt == DEPTH_W);
    end
  end

  // Sticky error flags; a new error beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (!flush_i && wrreq_i && full_q) begin
        ovf_q <= 1'b1;
      end else if (err_clr_i) begin
        ovf_q <= 1'b0;
      end
      if (!flush_i && rdreq_i && empty_w) begin
        unf_q <= 1'b1;
      end else if (err_clr_i) begin
        unf_q <= 1'b0;
      end
    end
  end

  // Output bypass register: overrides the RAM data when it is stale or reset
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      byp_sel_q  <= 1'b1;
      byp_data_q <= '0;
    end else if (flush_i) begin
      byp_sel_q  <= 1'b1;
      byp_data_q <= q_o;
    end else if (MODE == fifo_ext_pkg::SHOWAHEAD) begin
      if (collide) begin
        byp_sel_q  <= 1'b1;
        byp_data_q <= data_i;
      end else if (usedw_nxt == '0) begin
        // Nothing valid to show; freeze the current value
        byp_sel_q  <= 1'b1;
        byp_data_q <= q_o;
      end else begin
        byp_sel_q  <= 1'b0;
      end
    end else if (rd_acc) begin
      byp_sel_q <= 1'b0;
    end
  end

  fifo_ram #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[AWIDTH-1:0]),
    .wdata_i (data_i),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_q)
  );

  // Output mux and threshold comparisons
  always_comb begin
    q_o            = byp_sel_q ? byp_data_q : ram_q;
    empty_o        = empty_w;
    full_o         = full_q;
    usedw_o        = usedw_q;
    almost_full_o  = (usedw_q >= af_thresh_i);
    almost_empty_o = (usedw_q < ae_thresh_i);
    overflow_o     = ovf_q;
    underflow_o    = unf_q;
  end

endmodule
